// File: rtl/mmio_dev.sv
// Memory-mapped peripheral block with LED, switch, 7-seg and compare-match timer registers.
// Loads are combinational. Stores and the timer update on the rising edge of clk.
module mmio_dev #(
  parameter logic [31:0] BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMWr,
  input  logic [2:0]  DMType,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        hit,
  input  logic [15:0] sw_in,
  output logic [15:0] led,
  output logic [31:0] seg_data,
  output logic        irq
);

  localparam logic [5:0] IDX_LED  = 6'd0;
  localparam logic [5:0] IDX_SW   = 6'd1;
  localparam logic [5:0] IDX_CNT  = 6'd2;
  localparam logic [5:0] IDX_CMP  = 6'd3;
  localparam logic [5:0] IDX_CTRL = 6'd4;
  localparam logic [5:0] IDX_SEG  = 6'd5;

  logic [15:0] led_q, sw_s1, sw_s2;
  logic [31:0] cnt_q, cmp_q, seg_q;
  logic        en_q, ar_q, flag_q, irqen_q;

  logic [5:0]  idx;
  logic [31:0] rd_reg;
  logic [15:0] hv;
  logic [7:0]  bv;
  logic [3:0]  be;
  logic [31:0] wdat;
  logic        we, wr_led, wr_cnt, wr_cmp, wr_ctrl, wr_seg;
  logic        match, w1c;

  assign hit = (addr[31:8] == BASE[31:8]);
  assign idx = addr[7:2];

  always_comb begin
    rd_reg = '0;
    case (idx)
      IDX_LED:  rd_reg = {16'b0, led_q};
      IDX_SW:   rd_reg = {16'b0, sw_s2};
      IDX_CNT:  rd_reg = cnt_q;
      IDX_CMP:  rd_reg = cmp_q;
      IDX_CTRL: rd_reg = {28'b0, irqen_q, flag_q, ar_q, en_q};
      IDX_SEG:  rd_reg = seg_q;
      default:  rd_reg = '0;
    endcase
  end

  assign hv = addr[1] ? rd_reg[31:16] : rd_reg[15:0];
  assign bv = rd_reg[{addr[1:0], 3'b000} +: 8];

  // Reserved access types decode as word for loads, but never store.
  always_comb begin
    dout = '0;
    if (hit) begin
      case (DMType)
        3'd1:    if (!addr[0]) dout = {{16{hv[15]}}, hv};
        3'd2:    if (!addr[0]) dout = {16'b0, hv};
        3'd3:    dout = {{24{bv[7]}}, bv};
        3'd4:    dout = {24'b0, bv};
        default: if (addr[1:0] == 2'b00) dout = rd_reg;
      endcase
    end
  end

  // The store data is replicated across all lanes, and the byte enables pick the lanes that change.
  always_comb begin
    be   = 4'b0000;
    wdat = din;
    case (DMType)
      3'd0: if (addr[1:0] == 2'b00) be = 4'hF;
      3'd1, 3'd2: begin
        wdat = {2{din[15:0]}};
        if (!addr[0]) be = addr[1] ? 4'hC : 4'h3;
      end
      3'd3, 3'd4: begin
        wdat = {4{din[7:0]}};
        be   = 4'b0001 << addr[1:0];
      end
      default: be = 4'b0000;
    endcase
  end

  assign we      = DMWr && hit && (be != 4'b0000);
  assign wr_led  = we && (idx == IDX_LED);
  assign wr_cnt  = we && (idx == IDX_CNT);
  assign wr_cmp  = we && (idx == IDX_CMP);
  assign wr_ctrl = we && (idx == IDX_CTRL);
  assign wr_seg  = we && (idx == IDX_SEG);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m,
                                        input logic [31:0] nv);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = nv[8*i +: 8];
    return r;
  endfunction

  assign match = en_q && (cnt_q == cmp_q);
  assign w1c   = wr_ctrl && be[0] && wdat[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      seg_q   <= '0;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      flag_q  <= 1'b0;
      irqen_q <= 1'b0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
      if (wr_led && be[0]) led_q[7:0]  <= wdat[7:0];
      if (wr_led && be[1]) led_q[15:8] <= wdat[15:8];
      if (wr_cmp) cmp_q <= merge(cmp_q, be, wdat);
      if (wr_seg) seg_q <= merge(seg_q, be, wdat);
      // A CPU store to CNT overrides both the reload and the increment.
      if (wr_cnt)              cnt_q <= merge(cnt_q, be, wdat);
      else if (match && ar_q)  cnt_q <= '0;
      else if (en_q)           cnt_q <= cnt_q + 32'd1;
      if (wr_ctrl && be[0]) begin
        en_q    <= wdat[0];
        ar_q    <= wdat[1];
        irqen_q <= wdat[3];
      end
      flag_q <= match | (flag_q & ~w1c);
    end
  end

  assign led      = led_q;
  assign seg_data = seg_q;
  assign irq      = flag_q & irqen_q;

endmodule

// File: tb/tb_mmio_dev.sv
// Randomised and directed bench for mmio_dev.
// A register-level reference model supplies the expected values for every cycle.
module tb_mmio_dev;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst, DMWr, hit, irq;
  logic [2:0]  DMType;
  logic [31:0] addr, din, dout, seg_data;
  logic [15:0] sw_in, led;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] m_led, m_sw1, m_sw2, m_cnt, m_cmp, m_seg;
  bit          m_en, m_ar, m_flag, m_ie;

  mmio_dev #(.BASE(BASE)) dut (
    .clk(clk), .rst(rst), .DMWr(DMWr), .DMType(DMType), .addr(addr), .din(din),
    .dout(dout), .hit(hit), .sw_in(sw_in), .led(led), .seg_data(seg_data), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mreg(input int idx);
    case (idx)
      0: return m_led;
      1: return m_sw2;
      2: return m_cnt;
      3: return m_cmp;
      4: return 32'(m_en) + 32'(m_ar) * 2 + 32'(m_flag) * 4 + 32'(m_ie) * 8;
      5: return m_seg;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [2:0] t, input logic [31:0] a);
    logic [31:0] v, x;
    int k;
    if (a[31:8] != BASE[31:8]) return 32'h0;
    v = mreg(int'(a[7:2]));
    k = int'(a[1:0]);
    if (t == 3'd1 || t == 3'd2) begin
      if (k % 2 != 0) return 32'h0;
      x = (v >> (8 * k)) & 32'hFFFF;
      if (t == 3'd1 && x >= 32'h8000) x = x | 32'hFFFF_0000;
      return x;
    end
    if (t == 3'd3 || t == 3'd4) begin
      x = (v >> (8 * k)) & 32'hFF;
      if (t == 3'd3 && x >= 32'h80) x = x | 32'hFFFF_FF00;
      return x;
    end
    if (k != 0) return 32'h0;
    return v;
  endfunction

  task automatic mstep(input bit r, input bit wr, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic [15:0] sw);
    bit set, ok, nflag;
    logic [31:0] ncnt, nv, byt;
    int n, k, idx;
    if (r) begin
      m_led = 0; m_sw1 = 0; m_sw2 = 0; m_cnt = 0; m_cmp = 0; m_seg = 0;
      m_en = 0; m_ar = 0; m_flag = 0; m_ie = 0;
      return;
    end
    set   = m_en && (m_cnt == m_cmp);
    ncnt  = m_en ? ((set && m_ar) ? 32'h0 : m_cnt + 1) : m_cnt;
    nflag = m_flag | set;
    n = (t == 0) ? 4 : (t <= 2) ? 2 : 1;
    k = int'(a[1:0]);
    idx = int'(a[7:2]);
    ok = wr && (a[31:8] == BASE[31:8]) && (t <= 4) && (k % n == 0);
    if (ok) begin
      nv = mreg(idx);
      for (int b = 0; b < n; b++) begin
        byt = (d >> (8 * b)) & 32'hFF;
        nv = (nv & ~(32'hFF << (8 * (k + b)))) | (byt << (8 * (k + b)));
      end
      case (idx)
        0: m_led = nv & 32'hFFFF;
        2: ncnt = nv;
        3: m_cmp = nv;
        4: if (k == 0) begin
             m_en = nv[0]; m_ar = nv[1]; m_ie = nv[3];
             if (nv[2]) nflag = set;
           end
        5: m_seg = nv;
        default: ;
      endcase
    end
    m_cnt  = ncnt;
    m_flag = nflag;
    m_sw2  = m_sw1;
    m_sw1  = 32'(sw);
  endtask

  task automatic cyc(input bit wr, input logic [2:0] t, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rv);
    DMWr = wr; DMType = t; addr = a; din = d;
    #4;
    rv = dout;
    chk("hit", 32'(hit), 32'(a[31:8] == BASE[31:8]));
    chk("dout", dout, mread(t, a));
    chk("led", 32'(led), m_led);
    chk("seg", seg_data, m_seg);
    chk("irq", 32'(irq), 32'(m_flag & m_ie));
    @(posedge clk);
    mstep(rst, wr, t, a, d, sw_in);
    #1;
  endtask

  initial begin
    logic [31:0] rv, a, d;
    logic [2:0]  t;
    rst = 1; DMWr = 0; DMType = 0; addr = 0; din = 0; sw_in = 16'h0;
    @(posedge clk);
    mstep(1, 0, 0, 0, 0, 0);
    #1;
    // the register file must read back as zero while reset is held
    cyc(1, 0, BASE + 32'h14, 32'hDEAD_BEEF, rv);
    chk("rst_seg", seg_data, 32'h0);
    cyc(0, 0, BASE + 32'h14, 0, rv);
    chk("rst_rd", rv, 32'h0);
    rst = 0;

    // lane merge into SEG and signed byte load
    cyc(1, 0, BASE + 32'h14, 32'h1234_5678, rv);
    cyc(1, 4, BASE + 32'h15, 32'h0000_00AB, rv);
    cyc(0, 3, BASE + 32'h15, 0, rv);
    chk("seg_merge", seg_data, 32'h1234_AB78);
    chk("sbyte_rd", rv, 32'hFFFF_FFAB);

    // LED upper half is not stored; a misaligned half store is dropped
    cyc(1, 0, BASE, 32'h0000_1234, rv);
    cyc(1, 2, BASE + 32'h02, 32'h0000_BEEF, rv);
    cyc(0, 2, BASE + 32'h02, 0, rv);
    chk("led_hi_rd", rv, 32'h0);
    cyc(1, 1, BASE + 32'h01, 32'h0000_5555, rv);
    cyc(0, 0, BASE, 0, rv);
    chk("led_keep", rv, 32'h0000_1234);
    cyc(0, 1, BASE + 32'h01, 0, rv);
    chk("misal_rd", rv, 32'h0);

    // compare-match with autoreload and interrupt
    cyc(1, 0, BASE + 32'h0C, 32'd5, rv);
    cyc(1, 0, BASE + 32'h08, 32'd0, rv);
    cyc(1, 0, BASE + 32'h10, 32'hB, rv);
    for (int i = 0; i < 5; i++) cyc(0, 0, BASE + 32'h20, 0, rv);
    chk("irq_early", 32'(irq), 32'h0);
    cyc(0, 0, BASE + 32'h20, 0, rv);
    chk("irq_set", 32'(irq), 32'h1);
    cyc(0, 0, BASE + 32'h08, 0, rv);
    chk("cnt_reload", rv, 32'h0);
    cyc(1, 0, BASE + 32'h10, 32'h4, rv);
    chk("irq_clr", 32'(irq), 32'h0);
    cyc(0, 0, BASE + 32'h10, 0, rv);
    chk("ctrl_clr", rv, 32'h0);

    // counter wraps without a match
    cyc(1, 0, BASE + 32'h0C, 32'h10, rv);
    cyc(1, 0, BASE + 32'h08, 32'hFFFF_FFFE, rv);
    cyc(1, 0, BASE + 32'h10, 32'h1, rv);
    cyc(0, 0, BASE + 32'h08, 0, rv);
    chk("wrap0", rv, 32'hFFFF_FFFE);
    cyc(0, 0, BASE + 32'h08, 0, rv);
    chk("wrap1", rv, 32'hFFFF_FFFF);
    cyc(0, 0, BASE + 32'h08, 0, rv);
    chk("wrap2", rv, 32'h0);
    cyc(0, 0, BASE + 32'h10, 0, rv);
    chk("wrap_noflag", rv, 32'h1);

    // switch synchroniser latency, and stores outside the window
    sw_in = 16'hA5A5;
    cyc(0, 0, BASE + 32'h04, 0, rv);
    cyc(0, 0, BASE + 32'h04, 0, rv);
    chk("sw_lat", rv, 32'h0);
    cyc(0, 0, BASE + 32'h04, 0, rv);
    chk("sw_rd", rv, 32'h0000_A5A5);
    cyc(1, 0, 32'h1000_0014, 32'h5555_5555, rv);
    chk("out_hit", 32'(hit), 32'h0);
    chk("out_rd", rv, 32'h0);
    cyc(0, 0, BASE + 32'h14, 0, rv);
    chk("out_nowr", rv, 32'h1234_AB78);

    // reset in the middle of a count, with a CNT store on the same edge
    cyc(1, 0, BASE + 32'h10, 32'hB, rv);
    cyc(0, 0, BASE + 32'h20, 0, rv);
    rst = 1;
    cyc(1, 0, BASE + 32'h08, 32'h77, rv);
    rst = 0;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    cyc(0, 0, BASE + 32'h08, 0, rv);
    chk("rst_cnt", rv, 32'h0);

    // random traffic checked by the reference model
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) sw_in = 16'($urandom);
      t = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), t, a, d, rv);
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_dev.md
MMIO_DEV -- requirements
Module: mmio_dev

Interface
REQ-001 Parameter: BASE, default 32'hFFFF_0000, peripheral window base address; bits [7:0] SHALL be zero.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: DMWr  input  1  data-bus write strobe from CPU.
REQ-005 Port: DMType  input  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned.
REQ-006 Port: addr  input  32  full byte address from CPU.
REQ-007 Port: din  input  32  store data; byte/half values SHALL be taken from din[7:0] / din[15:0].
REQ-008 Port: dout  output  32  load data, extended per DMType.
REQ-009 Port: hit  output  1  high when addr[31:8] == BASE[31:8]; top level muxes dout on it.
REQ-010 Port: sw_in  input  16  asynchronous board switches.
REQ-011 Port: led  output  16  LED register contents.
REQ-012 Port: seg_data  output  32  seven-segment display value.
REQ-013 Port: irq  output  1  timer interrupt request.

Function
REQ-014 Register map (offset addr[7:0]) SHALL be: 0x00 LED (RW, bits 15:0; 31:16 read 0); 0x04 SW (RO); 0x08 CNT (RW); 0x0C CMP (RW); 0x10 CTRL (RW); 0x14 SEG (RW).
REQ-015 CTRL bits SHALL be: [0] EN, [1] AUTORELOAD, [2] FLAG (read; write-1-to-clear), [3] IRQEN; bits 31:4 read 0, writes ignored.
REQ-016 Reads SHALL be combinational, same cycle as addr; unmapped offsets and hit=0 SHALL give dout=0.
REQ-017 Read extraction: word = full register; half = register half selected by addr[1]; byte = lane selected by addr[1:0]; signed types sign-extend, unsigned zero-extend.
REQ-018 Write SHALL occur on the rising edge where DMWr=1 and hit=1; byte/half writes SHALL modify only the addressed lane(s).
REQ-019 Misaligned writes (half with addr[0]=1, word with addr[1:0]!=0) SHALL be ignored; misaligned reads SHALL return 0.
REQ-020 Writes to SW, unmapped offsets, or with DMType 101-111 SHALL be ignored; reads with DMType 101-111 SHALL behave as word.
REQ-021 sw_in SHALL pass a two-flop synchronizer; SW reads the second stage zero-extended (2-cycle latency).
REQ-022 When EN=1, CNT SHALL increment by 1 per cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-023 When EN=1 and CNT==CMP, FLAG SHALL set at that edge; with AUTORELOAD=1 CNT SHALL load 0 at that edge instead of incrementing.
REQ-024 A CPU write to CNT SHALL take priority over increment/reload in the same cycle.
REQ-025 FLAG set and W1C of FLAG in the same cycle: set SHALL win.
REQ-026 irq SHALL equal FLAG & IRQEN, combinational from registers.
REQ-027 led, seg_data SHALL reflect register contents from the cycle after the write.

Reset
REQ-028 With rst=1 at a rising edge: LED, CNT, CMP, CTRL, SEG, synchronizer flops SHALL clear to 0; led=0, seg_data=0, irq=0.
REQ-029 rst SHALL take priority over any simultaneous write or count; a count in progress SHALL be abandoned.
REQ-030 hit and dout SHALL stay combinational during reset (dout of SW/registers reads 0).

Verification
REQ-031 Word write 0x1234_5678 to SEG, then byte-unsigned write 0xAB at BASE+0x15 -> seg_data=0x1234_AB78; byte-signed read at BASE+0x15 -> dout=0xFFFF_FFAB.
REQ-032 Half write 0xBEEF at BASE+0x02 (LED) -> LED unchanged (bits 31:16 not stored), read 0; half write at BASE+0x01 -> ignored.
REQ-033 CMP=5, CTRL=0xB (EN|AUTORELOAD|IRQEN), CNT=0 -> FLAG and irq high 6 cycles after enable write; CNT=0 next; write 0x4 to CTRL (without EN bits restored) -> FLAG=0, irq=0.
REQ-034 CNT=0xFFFF_FFFE, EN=1, CMP=0x10 -> CNT 0xFFFF_FFFF then 0x0000_0000; no FLAG.
REQ-035 sw_in=0xA5A5 -> SW read returns 0x0000_A5A5 from second cycle after change; addr outside window -> hit=0, dout=0, writes do not alter state.
REQ-036 rst asserted mid-count with CPU writing CNT same edge -> all registers 0, irq=0 next cycle.
